fft_twiddle_seq: RTL and testbench

Sequencer that walks a 32-point radix-2 decimation-in-time FFT through its 5 stages × 16 butterflies and presents, per butterfly, the twiddle factor W32^k in the same signed fixed-point format the complex multiplier expects on its B inputs. It sits directly upstream of the multiplier's twiddle operand. It also emits the butterfly's data-memory address pair so the datapath can fetch the matching operand. A valid/ready handshake lets the downstream pipeline stall it.

---
 rtl/fft_twiddle_seq.sv | 193 +++++++++++++++++++
 tb/tb_fft_twiddle_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_seq.sv
`default_nettype none
// ============================================================================
// Module  : fft_twiddle_seq
// Purpose : Walks a 32-point radix-2 DIT FFT (5 stages x 16 butterflies) and
//           emits, per butterfly, the rounded twiddle W32^k plus operand
//           addresses behind a valid/ready handshake.
//           Address generation is built only with FFT_TWSEQ_ADDR_EN defined.
// Revision: 1.0  initial release
// ============================================================================
module fft_twiddle_seq #(
    parameter int p_inputWidth    = 8,
    parameter int p_PointPosition = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_ready,
    output logic                           o_valid,
    output logic signed [p_inputWidth-1:0] o_Wr,
    output logic signed [p_inputWidth-1:0] o_Wi,
    output logic        [2:0]              o_stage,
    output logic        [3:0]              o_bfly,
    output logic        [3:0]              o_k,
    output logic        [4:0]              o_addrTop,
    output logic        [4:0]              o_addrBot,
    output logic                           o_last,
    output logic                           o_done,
    output logic                           o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Q2.14 table is rescaled to P fraction bits with round-half-up; at P=14
    // there is nothing to round away.
    localparam int          c_SHIFT    = 14 - p_PointPosition;
    localparam int          c_HALF_EXP = (p_PointPosition >= 14) ? 0 : (13 - p_PointPosition);
    localparam logic [16:0] c_HALF     = (p_PointPosition >= 14) ? 17'd0 : (17'd1 << c_HALF_EXP);

    state_t                    r_state_q, w_state_d;
    logic                      r_valid_q, w_valid_d;
    logic [p_inputWidth-1:0]   r_wr_q, w_wr_d;
    logic [p_inputWidth-1:0]   r_wi_q, w_wi_d;
    logic [2:0]                r_stage_q, w_stage_d;
    logic [3:0]                r_bfly_q, w_bfly_d;
    logic [3:0]                r_k_q, w_k_d;
    logic [4:0]                r_addr_top_q, w_addr_top_d;
    logic [4:0]                r_addr_bot_q, w_addr_bot_d;
    logic                      r_last_q, w_last_d;
    logic                      r_done_q, w_done_d;
    logic                      r_busy_q, w_busy_d;

    logic                      w_accept;
    logic [3:0]                w_mask;
    logic [3:0]                w_k;

    function automatic logic [14:0] qcos(input logic [3:0] idx);
        case (idx)
            4'd0:    qcos = 15'd16384;
            4'd1:    qcos = 15'd16069;
            4'd2:    qcos = 15'd15137;
            4'd3:    qcos = 15'd13623;
            4'd4:    qcos = 15'd11585;
            4'd5:    qcos = 15'd9102;
            4'd6:    qcos = 15'd6270;
            4'd7:    qcos = 15'd3196;
            default: qcos = 15'd0;
        endcase
    endfunction

    function automatic logic [p_inputWidth-1:0] mag(input logic [3:0] idx);
        logic [16:0] sum;
        sum = ({2'b00, qcos(idx)} + c_HALF) >> c_SHIFT;
        mag = p_inputWidth'(sum);
    endfunction

    assign w_accept = r_valid_q & i_ready;

    always_comb begin
        w_state_d = r_state_q;
        w_stage_d = r_stage_q;
        w_bfly_d  = r_bfly_q;

        case (r_state_q)
            S_IDLE: begin
                if (i_start) begin
                    w_state_d = S_RUN;
                    w_stage_d = 3'd0;
                    w_bfly_d  = 4'd0;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    if (r_last_q) begin
                        w_state_d = S_DONE;
                        w_stage_d = 3'd0;
                        w_bfly_d  = 4'd0;
                    end else if (r_bfly_q == 4'd15) begin
                        w_bfly_d  = 4'd0;
                        w_stage_d = r_stage_q + 3'd1;
                    end else begin
                        w_bfly_d  = r_bfly_q + 4'd1;
                    end
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase

        w_valid_d = (w_state_d == S_RUN);
        w_busy_d  = w_valid_d;
        w_done_d  = (w_state_d == S_DONE);
        w_last_d  = w_valid_d && (w_stage_d == 3'd4) && (w_bfly_d == 4'd15);

        // Payload is derived from the next counters, so a stalled beat simply
        // recomputes identical values and the outputs hold.
        w_mask = 4'((5'd1 << w_stage_d) - 5'd1);
        w_k    = (w_bfly_d & w_mask) << (3'd4 - w_stage_d);

        if (w_k <= 4'd8) begin
            w_wr_d = mag(w_k);
            w_wi_d = -mag(4'd8 - w_k);
        end else begin
            w_wr_d = -mag(4'(5'd16 - {1'b0, w_k}));
            w_wi_d = -mag(w_k - 4'd8);
        end

`ifdef FFT_TWSEQ_ADDR_EN
        w_addr_top_d = 5'((({1'b0, w_bfly_d} >> w_stage_d) << (w_stage_d + 3'd1))
                          | {1'b0, w_bfly_d & w_mask});
        w_addr_bot_d = w_addr_top_d + 5'(5'd1 << w_stage_d);
`else
        w_addr_top_d = 5'd0;
        w_addr_bot_d = 5'd0;
`endif

        w_k_d = w_k;
        if (!w_valid_d) begin
            w_wr_d       = '0;
            w_wi_d       = '0;
            w_k_d        = 4'd0;
            w_addr_top_d = 5'd0;
            w_addr_bot_d = 5'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q    <= S_IDLE;
            r_valid_q    <= 1'b0;
            r_wr_q       <= '0;
            r_wi_q       <= '0;
            r_stage_q    <= 3'd0;
            r_bfly_q     <= 4'd0;
            r_k_q        <= 4'd0;
            r_addr_top_q <= 5'd0;
            r_addr_bot_q <= 5'd0;
            r_last_q     <= 1'b0;
            r_done_q     <= 1'b0;
            r_busy_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_valid_q    <= w_valid_d;
            r_wr_q       <= w_wr_d;
            r_wi_q       <= w_wi_d;
            r_stage_q    <= w_stage_d;
            r_bfly_q     <= w_bfly_d;
            r_k_q        <= w_k_d;
            r_addr_top_q <= w_addr_top_d;
            r_addr_bot_q <= w_addr_bot_d;
            r_last_q     <= w_last_d;
            r_done_q     <= w_done_d;
            r_busy_q     <= w_busy_d;
        end
    end

    assign o_valid   = r_valid_q;
    assign o_Wr      = r_wr_q;
    assign o_Wi      = r_wi_q;
    assign o_stage   = r_stage_q;
    assign o_bfly    = r_bfly_q;
    assign o_k       = r_k_q;
    assign o_addrTop = r_addr_top_q;
    assign o_addrBot = r_addr_bot_q;
    assign o_last    = r_last_q;
    assign o_done    = r_done_q;
    assign o_busy    = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_twiddle_seq
// Purpose : Scoreboard bench for fft_twiddle_seq (W=8, P=3): reset, full
//           sweeps, backpressure and ignored start. Honours FFT_TWSEQ_ADDR_EN.
// Revision: 1.0  initial release
// ============================================================================
module tb_fft_twiddle_seq;

    localparam int W = 8;
    localparam int P = 3;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_start;
    logic                i_ready;
    logic                o_valid;
    logic signed [W-1:0] o_Wr;
    logic signed [W-1:0] o_Wi;
    logic [2:0]          o_stage;
    logic [3:0]          o_bfly;
    logic [3:0]          o_k;
    logic [4:0]          o_addrTop;
    logic [4:0]          o_addrBot;
    logic                o_last;
    logic                o_done;
    logic                o_busy;

    fft_twiddle_seq #(
        .p_inputWidth    (W),
        .p_PointPosition (P)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_Wr      (o_Wr),
        .o_Wi      (o_Wi),
        .o_stage   (o_stage),
        .o_bfly    (o_bfly),
        .o_k       (o_k),
        .o_addrTop (o_addrTop),
        .o_addrBot (o_addrBot),
        .o_last    (o_last),
        .o_done    (o_done),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int s;
        int b;
        int k;
        int wr;
        int wi;
        int at;
        int ab;
        int last;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Round-half-up rescale of the Q2.14 quarter-wave magnitude to P bits.
    function automatic int mag(input int idx);
        int c[9] = '{16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196, 0};
        return (c[idx] * (1 << P) + 8192) / 16384;
    endfunction

    function automatic beat_t model(input int s, input int b);
        beat_t e;
        e.s = s;
        e.b = b;
        e.k = (b % (1 << s)) * (1 << (4 - s));
        if (e.k <= 8) begin
            e.wr = mag(e.k);
            e.wi = -mag(8 - e.k);
        end else begin
            e.wr = -mag(16 - e.k);
            e.wi = -mag(e.k - 8);
        end
`ifdef FFT_TWSEQ_ADDR_EN
        e.at = (b / (1 << s)) * (1 << (s + 1)) + (b % (1 << s));
        e.ab = e.at + (1 << s);
`else
        e.at = 0;
        e.ab = 0;
`endif
        e.last = (s == 4 && b == 15) ? 1 : 0;
        return e;
    endfunction

    task automatic push_transform();
        for (int s = 0; s < 5; s++)
            for (int b = 0; b < 16; b++)
                sb.push_back(model(s, b));
    endtask

    task automatic cmp_beat(input string pfx, input beat_t e);
        chk({pfx, "_stage"}, o_stage, e.s);
        chk({pfx, "_bfly"},  o_bfly,  e.b);
        chk({pfx, "_k"},     o_k,     e.k);
        chk({pfx, "_wr"},    o_Wr,    e.wr);
        chk({pfx, "_wi"},    o_Wi,    e.wi);
        chk({pfx, "_atop"},  o_addrTop, e.at);
        chk({pfx, "_abot"},  o_addrBot, e.ab);
        chk({pfx, "_last"},  o_last,  e.last);
    endtask

    // Hand-derived reference points for W=8, P=3.
    task automatic cmp_known(input beat_t e);
        if (e.s == 0) chk("s0_k_zero", o_k, 0);
        if (e.s == 0 && e.b == 0) begin
            chk("b00_wr", o_Wr, 8);
            chk("b00_wi", o_Wi, 0);
        end
`ifdef FFT_TWSEQ_ADDR_EN
        if (e.s == 0 && e.b == 3) begin
            chk("b03_atop", o_addrTop, 6);
            chk("b03_abot", o_addrBot, 7);
        end
        if (e.s == 4 && e.b == 12) begin
            chk("b412_atop", o_addrTop, 12);
            chk("b412_abot", o_addrBot, 28);
        end
`else
        chk("noaddr_top", o_addrTop, 0);
        chk("noaddr_bot", o_addrBot, 0);
`endif
        if (e.s == 4) begin
            case (e.b)
                2:  begin chk("k2_wr",  o_Wr, 7);  chk("k2_wi",  o_Wi, -3); end
                4:  begin chk("k4_wr",  o_Wr, 6);  chk("k4_wi",  o_Wi, -6); end
                8:  begin chk("k8_wr",  o_Wr, 0);  chk("k8_wi",  o_Wi, -8); end
                12: begin chk("k12_k", o_k, 12); chk("k12_wr", o_Wr, -6); chk("k12_wi", o_Wi, -6); end
                14: begin chk("k14_wr", o_Wr, -7); chk("k14_wi", o_Wi, -3); end
                15: chk("last_at_415", o_last, 1);
                default: ;
            endcase
        end
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_valid"}, o_valid, 0);
        chk({pfx, "_wr"},    o_Wr, 0);
        chk({pfx, "_wi"},    o_Wi, 0);
        chk({pfx, "_stage"}, o_stage, 0);
        chk({pfx, "_bfly"},  o_bfly, 0);
        chk({pfx, "_k"},     o_k, 0);
        chk({pfx, "_atop"},  o_addrTop, 0);
        chk({pfx, "_abot"},  o_addrBot, 0);
        chk({pfx, "_last"},  o_last, 0);
        chk({pfx, "_done"},  o_done, 0);
        chk({pfx, "_busy"},  o_busy, 0);
    endtask

    // Runs one transform from IDLE. Optional 3-cycle stall at (stall_s,stall_b)
    // and an extra i_start pulse once busy_start_at beats have transferred.
    task automatic run_transform(input string pfx, input int stall_s, input int stall_b,
                                 input int busy_start_at);
        int    beats      = 0;
        int    cyc        = 0;
        int    done_cyc   = -1;
        int    stall_left = 0;
        bit    stalled    = 0;
        bit    pulsed     = 0;
        beat_t e;

        sb.delete();
        push_transform();
        i_start = 1'b1;
        i_ready = 1'b1;
        while (cyc < 400) begin
            @(negedge i_clk);
            cyc++;
            i_start = 1'b0;
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
            if (busy_start_at >= 0 && beats == busy_start_at && !pulsed) begin
                i_start = 1'b1;
                pulsed  = 1'b1;
            end
            if (stall_left > 0) begin
                cmp_beat({pfx, "_hold"}, sb[0]);
                chk({pfx, "_hold_valid"}, o_valid, 1);
                stall_left--;
                i_ready = 1'b0;
            end else if (!stalled && stall_s >= 0 && o_valid &&
                         o_stage == 3'(stall_s) && o_bfly == 4'(stall_b)) begin
                chk({pfx, "_stall_k"}, o_k, 4);
                stalled    = 1'b1;
                stall_left = 2;
                i_ready    = 1'b0;
            end else begin
                i_ready = 1'b1;
                chk({pfx, "_valid"}, o_valid, 1);
                chk({pfx, "_busy"},  o_busy, 1);
                if (o_valid) begin
                    if (sb.size() == 0) begin
                        chk({pfx, "_sb_underflow"}, 1, 0);
                    end else begin
                        e = sb.pop_front();
                        cmp_beat(pfx, e);
                        cmp_known(e);
                    end
                    beats++;
                end
            end
        end
        i_ready = 1'b1;
        chk({pfx, "_beats"},    beats, 80);
        chk({pfx, "_sb_empty"}, sb.size(), 0);
        chk({pfx, "_done_cyc"}, done_cyc, stalled ? 84 : 81);
        chk({pfx, "_done_valid"}, o_valid, 0);
        chk({pfx, "_done_busy"},  o_busy, 0);
        @(negedge i_clk);
        chk({pfx, "_idle_done"},  o_done, 0);
        chk({pfx, "_idle_valid"}, o_valid, 0);
        chk({pfx, "_idle_busy"},  o_busy, 0);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check_all_zero("reset");

        // Start, run to beat 10, then reset with the beat on the bus.
        i_start = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            chk("prerst_valid", o_valid, 1);
            chk("prerst_bfly",  o_bfly, i);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check_all_zero("midrst");

        run_transform("sweep", -1, -1, -1);
        run_transform("bp", 2, 5, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
